// File: rtl/regfile_dump_reader_pkg.sv
// ----------------------------------------------------------------------------
// regfile_dump_reader_pkg
//   Shared constants and types for the MIPS register-file debug dump reader.
//   Defines the register-file geometry, the dump FSM state type and small
//   helpers for range validation and index stepping.
//   No ports (package).
// ----------------------------------------------------------------------------
package regfile_dump_reader_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  // A dump request is only meaningful when the range is non-empty.
  function automatic logic range_valid(input reg_addr_t first, input reg_addr_t last);
    return (first <= last);
  endfunction

  // Step to the following register index.
  function automatic reg_addr_t next_idx(input reg_addr_t idx);
    return idx + reg_addr_t'(1);
  endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// ----------------------------------------------------------------------------
// regfile_dump_reader_if
//   valid/ready beat stream from the dump reader to the debug/trace unit.
//   Signals:
//     out_valid  beat valid (producer)
//     out_ready  consumer ready (consumer)
//     out_idx    register index of the beat (producer)
//     out_data   register contents of the beat (producer)
//     out_last   beat is the last of the requested range (producer)
//   Modports: master = dump reader side, slave = trace unit side.
// ----------------------------------------------------------------------------
interface regfile_dump_reader_if;
  import regfile_dump_reader_pkg::*;

  logic      out_valid;
  logic      out_ready;
  reg_addr_t out_idx;
  reg_data_t out_data;
  logic      out_last;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// ----------------------------------------------------------------------------
// regfile_dump_reader
//   Debug read-side client of the 32x32 MIPS register file. On start it walks
//   the register range [first_idx..last_idx] through a dedicated read port and
//   streams each word as (index, data, last) beats. Never writes the RF.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               dump request, sampled only while idle
//   abort               cancel a dump in progress
//   first_idx/last_idx  inclusive range, latched when start is accepted
//   rd_addr             registered read address to the RF debug port
//   rd_data             combinational RF read data for rd_addr
//   out_if              beat stream (master modport)
//   busy                high whenever not idle
//   done                one-cycle pulse once the whole range is delivered
//   err                 one-cycle pulse after a start with first_idx > last_idx
// ----------------------------------------------------------------------------
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  reg_addr_t                    first_idx,
  input  reg_addr_t                    last_idx,
  output reg_addr_t                    rd_addr,
  input  reg_data_t                    rd_data,
  regfile_dump_reader_if.master        out_if,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  dump_state_t state_q,     state_d;
  reg_addr_t   last_q,      last_d;
  reg_addr_t   rd_addr_q,   rd_addr_d;
  reg_addr_t   out_idx_q,   out_idx_d;
  reg_data_t   out_data_q,  out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q,  out_last_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        err_q,       err_d;

  logic        handshake_s;

  assign handshake_s = out_valid_q & out_if.out_ready;

  // Next-state and next-output logic for the dump sequencer.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    rd_addr_d   = rd_addr_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (range_valid(first_idx, last_idx)) begin
            last_d    = last_idx;
            rd_addr_d = first_idx;
            state_d   = READ;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      // rd_addr has been stable for this whole cycle, so rd_data is settled.
      READ: begin
        out_data_d  = rd_data;
        out_idx_d   = rd_addr_q;
        out_last_d  = (rd_addr_q == last_q);
        out_valid_d = 1'b1;
        state_d     = SEND;
      end

      SEND: begin
        if (handshake_s) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            // Stop on the last index: never step past it, so 31 does not wrap to 0.
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            rd_addr_d = next_idx(rd_addr_q);
            state_d   = READ;
          end
        end else begin
          state_d = SEND;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Abort overrides everything except reset; the in-flight beat is withdrawn.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end else begin
      state_d = state_d;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any dump in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= '0;
      rd_addr_q   <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rd_addr_q   <= rd_addr_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rd_addr          = rd_addr_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_idx   = out_idx_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// ----------------------------------------------------------------------------
// tb_regfile_dump_reader
//   Self-checking bench: a behavioural model (expected-beat queue built from
//   the register-file contents) is compared against the DUT every cycle, and
//   directed scenarios add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  logic      clk;
  logic      rst;
  logic      start;
  logic      abort;
  reg_addr_t first_idx;
  reg_addr_t last_idx;
  reg_addr_t rd_addr;
  reg_data_t rd_data;
  logic      busy;
  logic      done;
  logic      err;

  logic [31:0] rf [32];

  int n_checks = 0;
  int n_errors = 0;

  regfile_dump_reader_if out_if ();

  regfile_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_if    (out_if),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  assign rd_data = rf[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  logic  m_known   = 1'b0;
  logic  m_busy    = 1'b0;
  logic  m_in_done = 1'b0;
  logic  m_err     = 1'b0;

  // Compare on the falling edge, then advance the model with the inputs the
  // next rising edge will sample.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (m_known) begin
        check("busy", {63'd0, busy}, {63'd0, m_busy});
        check("done", {63'd0, done}, {63'd0, m_in_done});
        check("err", {63'd0, err}, {63'd0, m_err});
        if (!m_busy) check("valid_idle", {63'd0, out_if.out_valid}, 64'd0);
        if (out_if.out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'd1, 64'd0);
          end else begin
            b = exp_q[0];
            check("beat_idx", {59'd0, out_if.out_idx}, {59'd0, b.idx});
            check("beat_data", {32'd0, out_if.out_data}, {32'd0, b.data});
            check("beat_last", {63'd0, out_if.out_last}, {63'd0, b.last});
          end
        end
      end
      if (rst) begin
        exp_q.delete();
        m_busy    = 1'b0;
        m_in_done = 1'b0;
        m_err     = 1'b0;
        m_known   = 1'b1;
      end else if (m_known) begin
        m_err = 1'b0;
        if (m_in_done) begin
          m_in_done = 1'b0;
          m_busy    = 1'b0;
        end else if (!m_busy) begin
          if (start) begin
            if (first_idx <= last_idx) begin
              m_busy = 1'b1;
              for (int i = int'(first_idx); i <= int'(last_idx); i++) begin
                b.idx  = 5'(i);
                b.data = rf[i];
                b.last = (i == int'(last_idx));
                exp_q.push_back(b);
              end
            end else begin
              m_err = 1'b1;
            end
          end
        end else if (abort) begin
          exp_q.delete();
          m_busy = 1'b0;
        end else if (out_if.out_valid && out_if.out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_in_done = 1'b1;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int budget,
                          output int cyc, output int nbeats, output int nlast,
                          output int fv_cyc, output logic [4:0] fv_idx, output logic [31:0] fv_data,
                          output logic [4:0] lb_idx, output logic [31:0] lb_data);
    logic got;
    first_idx = f;
    last_idx  = l;
    start     = 1'b1;
    tick();
    start   = 1'b0;
    cyc     = 0;
    nbeats  = 0;
    nlast   = 0;
    fv_cyc  = -1;
    fv_idx  = 5'd0;
    fv_data = 32'd0;
    lb_idx  = 5'd0;
    lb_data = 32'd0;
    got     = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      tick();
      cyc++;
      if (out_if.out_valid && fv_cyc < 0) begin
        fv_cyc  = cyc;
        fv_idx  = out_if.out_idx;
        fv_data = out_if.out_data;
      end
      if (out_if.out_valid && out_if.out_ready) begin
        nbeats++;
        if (out_if.out_last) begin
          nlast++;
          lb_idx  = out_if.out_idx;
          lb_data = out_if.out_data;
        end
      end
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_addr"}, {59'd0, rd_addr}, 64'd0);
    check({tag, "_out_idx"}, {59'd0, out_if.out_idx}, 64'd0);
    check({tag, "_out_data"}, {32'd0, out_if.out_data}, 64'd0);
    check({tag, "_out_valid"}, {63'd0, out_if.out_valid}, 64'd0);
    check({tag, "_out_last"}, {63'd0, out_if.out_last}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, nb, nl, fvc;
    logic [4:0]  fvi, lbi;
    logic [31:0] fvd, lbd;
    logic        stalled, got;

    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rst              = 1'b1;
    start            = 1'b0;
    abort            = 1'b0;
    first_idx        = 5'd0;
    last_idx         = 5'd0;
    out_if.out_ready = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Full range 0..31 with ready tied high.
    run_dump(5'd0, 5'd31, 200, cyc, nb, nl, fvc, fvi, fvd, lbi, lbd);
    check("full_cycles", 64'(cyc), 64'd64);
    check("full_beats", 64'(nb), 64'd32);
    check("full_nlast", 64'(nl), 64'd1);
    check("full_first_latency", 64'(fvc), 64'd1);
    check("full_first_idx", {59'd0, fvi}, 64'd0);
    check("full_first_data", {32'd0, fvd}, 64'h1000_0000);
    check("full_last_idx", {59'd0, lbi}, 64'd31);
    check("full_last_data", {32'd0, lbd}, 64'h1000_001F);
    tick();
    check("full_busy_after", {63'd0, busy}, 64'd0);
    check("full_rd_addr_nowrap", {59'd0, rd_addr}, 64'd31);

    // Single-register range.
    run_dump(5'd5, 5'd5, 50, cyc, nb, nl, fvc, fvi, fvd, lbi, lbd);
    check("single_cycles", 64'(cyc), 64'd2);
    check("single_beats", 64'(nb), 64'd1);
    check("single_last_idx", {59'd0, lbi}, 64'd5);
    check("single_last_data", {32'd0, lbd}, 64'h1000_0005);
    tick();
    check("single_busy_after", {63'd0, busy}, 64'd0);

    // Rejected range.
    first_idx = 5'd10;
    last_idx  = 5'd3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("rej_err_pulse", {63'd0, err}, 64'd1);
    check("rej_busy", {63'd0, busy}, 64'd0);
    check("rej_valid", {63'd0, out_if.out_valid}, 64'd0);
    tick();
    check("rej_err_clear", {63'd0, err}, 64'd0);
    check("rej_busy2", {63'd0, busy}, 64'd0);

    // Back-pressure: hold beat idx 3 for 7 cycles.
    first_idx = 5'd2;
    last_idx  = 5'd4;
    start     = 1'b1;
    tick();
    start   = 1'b0;
    stalled = 1'b0;
    got     = 1'b0;
    nb      = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      if (done) got = 1'b1;
      if (out_if.out_valid && out_if.out_ready) nb++;
      if (out_if.out_valid && out_if.out_idx == 5'd3 && !stalled) begin
        out_if.out_ready = 1'b0;
        nb--;
        for (int s = 0; s < 7; s++) begin
          tick();
          check("stall_valid", {63'd0, out_if.out_valid}, 64'd1);
          check("stall_idx", {59'd0, out_if.out_idx}, 64'd3);
          check("stall_data", {32'd0, out_if.out_data}, 64'h1000_0003);
        end
        out_if.out_ready = 1'b1;
        nb++;
        stalled = 1'b1;
      end
    end
    if (!got) check("stall_done_timeout", 64'd0, 64'd1);
    check("stall_beats", 64'(nb), 64'd3);
    tick();

    // Abort during SEND of idx 7 in range 0..15.
    first_idx = 5'd0;
    last_idx  = 5'd15;
    start     = 1'b1;
    tick();
    start = 1'b0;
    got   = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      if (out_if.out_valid && out_if.out_idx == 5'd7) got = 1'b1;
    end
    if (!got) check("abort_reach_timeout", 64'd0, 64'd1);
    out_if.out_ready = 1'b0;
    abort            = 1'b1;
    tick();
    abort            = 1'b0;
    out_if.out_ready = 1'b1;
    check("abort_valid", {63'd0, out_if.out_valid}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_done", {63'd0, done}, 64'd0);
    end
    run_dump(5'd0, 5'd2, 50, cyc, nb, nl, fvc, fvi, fvd, lbi, lbd);
    check("restart_beats", 64'(nb), 64'd3);
    check("restart_first_idx", {59'd0, fvi}, 64'd0);
    check("restart_last_data", {32'd0, lbd}, 64'h1000_0002);
    tick();

    // Reset mid-dump, with a start pulsed while busy (ignored, no err).
    first_idx = 5'd0;
    last_idx  = 5'd31;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    first_idx = 5'd25;
    last_idx  = 5'd20;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_busy", {63'd0, busy}, 64'd1);
    tick();
    check("busy_start_no_err", {63'd0, err}, 64'd0);
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    tick();
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    run_dump(5'd3, 5'd4, 50, cyc, nb, nl, fvc, fvi, fvd, lbi, lbd);
    check("post_rst_beats", 64'(nb), 64'd2);
    check("post_rst_last_idx", {59'd0, lbi}, 64'd4);
    check("post_rst_last_data", {32'd0, lbd}, 64'h1000_0004);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
